// File: rtl/vie_mem_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline: holds the execute-stage bus,
// waits for the data-SRAM response on loads, extends load data and forwards to decode.
module vie_mem_stage (
    input  logic        clock,
    input  logic        reset,
    input  logic [75:0] esbus_i,
    output logic        ms_allowin,
    input  logic        ws_allowin,
    input  logic        data_ok,
    input  logic [31:0] data_rdata,
    output logic [71:0] msbus_o,
    output logic [38:0] fwdbus_o
);

    typedef struct packed {
        logic [6:0]  dest;
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic        is_load;
        logic [2:0]  load_op;
    } es_payload_t;

    typedef enum logic [2:0] {
        OP_LB  = 3'b000,
        OP_LBU = 3'b001,
        OP_LH  = 3'b010,
        OP_LHU = 3'b011,
        OP_LW  = 3'b100
    } load_op_e;

    logic        es_valid;
    es_payload_t es_payload;

    logic        ms_valid_r;
    es_payload_t ms_r;
    logic        buf_valid;
    logic [31:0] buf_data;

    logic        ms_cango;
    logic        ms_out_valid;
    logic        ms_leave;
    logic        buf_capture;

    logic [1:0]  byte_addr;
    logic [31:0] raw_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] ms_res;
    logic        fwd_valid;
    logic        fwd_pending;

    assign es_valid   = esbus_i[75];
    assign es_payload = esbus_i[74:0];

    // A load may only proceed once its data is on the bus or already buffered.
    assign ms_cango     = !ms_r.is_load || data_ok || buf_valid;
    assign ms_allowin   = !ms_valid_r || (ms_cango && ws_allowin);
    assign ms_out_valid = ms_valid_r && ms_cango;
    assign ms_leave     = ms_out_valid && ws_allowin;

    // Only hold the response when writeback stalls; otherwise it passes straight through.
    assign buf_capture = ms_valid_r && ms_r.is_load && data_ok && !buf_valid && !ws_allowin;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
            ms_r       <= '0;
            buf_valid  <= 1'b0;
            buf_data   <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid_r <= es_valid;
            end
            if (es_valid && ms_allowin) begin
                ms_r <= es_payload;
            end
            if (ms_leave) begin
                buf_valid <= 1'b0;
            end else if (buf_capture) begin
                buf_valid <= 1'b1;
                buf_data  <= data_rdata;
            end
        end
    end

    assign byte_addr = ms_r.alu_res[1:0];
    assign raw_data  = buf_valid ? buf_data : data_rdata;

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        load_byte = raw_data[7:0];
        load_half = raw_data[15:0];
        load_data = raw_data;

        case (byte_addr)
            2'd1:    load_byte = raw_data[15:8];
            2'd2:    load_byte = raw_data[23:16];
            2'd3:    load_byte = raw_data[31:24];
            default: load_byte = raw_data[7:0];
        endcase

        if (byte_addr[1]) begin
            load_half = raw_data[31:16];
        end

        case (load_op_e'(ms_r.load_op))
            OP_LB:   load_data = {{24{load_byte[7]}}, load_byte};
            OP_LBU:  load_data = {24'd0, load_byte};
            OP_LH:   load_data = {{16{load_half[15]}}, load_half};
            OP_LHU:  load_data = {16'd0, load_half};
            default: load_data = raw_data;
        endcase
    end

    assign ms_res = ms_r.is_load ? load_data : ms_r.alu_res;

    // Only architectural GPRs (dest[6:5]==0) other than $0 are forwarded.
    assign fwd_valid   = ms_valid_r && (ms_r.dest[6:5] == 2'b00) && (ms_r.dest[4:0] != 5'd0);
    assign fwd_pending = fwd_valid && !ms_cango;

    assign msbus_o  = {ms_out_valid, ms_r.dest, ms_r.pc, ms_res};
    assign fwdbus_o = {fwd_valid, fwd_pending, ms_r.dest[4:0], ms_res};

endmodule

// File: tb/tb_vie_mem_stage.sv
// Self-checking bench for vie_mem_stage: directed scenarios plus randomized traffic,
// all outputs compared by a scoreboard monitor against expected entries queued at issue.
module tb_vie_mem_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [75:0] esbus_i = '0;
    logic        ms_allowin;
    logic        ws_allowin = 1'b1;
    logic        data_ok = 1'b0;
    logic [31:0] data_rdata = '0;
    logic [71:0] msbus_o;
    logic [38:0] fwdbus_o;

    int checks   = 0;
    int failures = 0;

    logic [71:0] exp_q[$];
    logic [71:0] mon_e;

    logic [31:0] pend_rdata[$];
    int          pend_delay[$];
    logic [6:0]  pend_dest[$];

    localparam logic [75:0] IDLE = '0;

    vie_mem_stage dut (
        .clock      (clock),
        .reset      (reset),
        .esbus_i    (esbus_i),
        .ms_allowin (ms_allowin),
        .ws_allowin (ws_allowin),
        .data_ok    (data_ok),
        .data_rdata (data_rdata),
        .msbus_o    (msbus_o),
        .fwdbus_o   (fwdbus_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [75:0] mk(input logic v, input logic [6:0] d, input logic [31:0] pc,
                                       input logic [31:0] alu, input logic ld, input logic [2:0] op);
        return {v, d, pc, alu, ld, op};
    endfunction

    function automatic logic [71:0] expv(input logic [6:0] d, input logic [31:0] pc, input logic [31:0] res);
        return {1'b1, d, pc, res};
    endfunction

    function automatic logic fwd_ok(input logic [6:0] d);
        return (d[6:5] == 2'b00) && (d[4:0] != 5'd0);
    endfunction

    function automatic logic [38:0] exp_fwd(input logic [71:0] e);
        return {fwd_ok(e[70:64]), 1'b0, e[68:64], e[31:0]};
    endfunction

    // Reference load extension computed arithmetically from the addressed byte/halfword.
    function automatic logic [31:0] load_model(input logic [2:0] op, input logic [31:0] addr,
                                               input logic [31:0] raw);
        int unsigned b;
        int unsigned h;
        b = (raw >> (int'(addr[1:0]) * 8)) & 32'hFF;
        h = addr[1] ? (raw >> 16) : (raw & 32'hFFFF);
        case (op)
            3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
            3'd1:    return b;
            3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
            3'd3:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic logic [75:0] rand_bus();
        logic [6:0] d;
        d[4:0] = 5'($urandom());
        d[6:5] = ($urandom_range(0, 3) == 0) ? 2'($urandom()) : 2'b00;
        return mk($urandom_range(0, 9) < 7, d, $urandom(), $urandom(),
                  $urandom_range(0, 1) == 1, 3'($urandom()));
    endfunction

    // Apply one cycle of inputs just after the rising edge; return at the falling edge.
    task automatic drive(input logic [75:0] es, input logic wsa, input logic dok, input logic [31:0] rd);
        @(posedge clock);
        #1;
        esbus_i    = es;
        ws_allowin = wsa;
        data_ok    = dok;
        data_rdata = rd;
        @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (!reset && msbus_o[71] && ws_allowin) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_output: got %h expected none", msbus_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_msbus", msbus_o, mon_e);
                check("sb_fwdbus", 72'(fwdbus_o), 72'(exp_fwd(mon_e)));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [75:0] es;
        logic [75:0] ld;
        logic        wsa;
        logic        dok;
        logic        served;
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [2:0]  ops[5];
        logic [31:0] addrs[5];
        logic [31:0] rdatas[5];
        logic [31:0] ress[5];
        int          waits[5];

        // Reset state
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("reset_allowin", ms_allowin, 1);
        check("reset_msbus", msbus_o, 0);
        check("reset_fwdbus", fwdbus_o, 0);

        // ALU instruction: visible exactly one cycle after acceptance
        drive(mk(1'b1, 7'd3, 32'hBFC0_0000, 32'h1234_5678, 1'b0, 3'd0), 1'b1, 1'b0, 32'h0);
        check("alu_allowin", ms_allowin, 1);
        exp_q.push_back(expv(7'd3, 32'hBFC0_0000, 32'h1234_5678));
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("alu_msbus", msbus_o, expv(7'd3, 32'hBFC0_0000, 32'h1234_5678));
        check("alu_fwd_valid", fwdbus_o[38], 1);
        check("alu_fwd_pending", fwdbus_o[37], 0);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("alu_gone", msbus_o[71], 0);

        // Load extension cases: lb/lbu with late data, lh/lhu/lw with immediate data
        ops    = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        addrs  = '{32'h0000_1001, 32'h0000_1001, 32'h0000_2002, 32'h0000_2002, 32'h0000_2002};
        rdatas = '{32'h0000_80FF, 32'h0000_80FF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF};
        ress   = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'h8001_7FFF};
        waits  = '{2, 2, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            drive(mk(1'b1, 7'd9, 32'h8000_0100 + 32'(i * 4), addrs[i], 1'b1, ops[i]),
                  1'b1, 1'b0, 32'h0);
            exp_q.push_back(expv(7'd9, 32'h8000_0100 + 32'(i * 4), ress[i]));
            for (int w = 0; w < waits[i]; w++) begin
                drive(IDLE, 1'b1, 1'b0, 32'hFFFF_FFFF);
                check("ld_wait_allowin", ms_allowin, 0);
                check("ld_wait_pending", fwdbus_o[37], 1);
                check("ld_wait_valid", msbus_o[71], 0);
            end
            drive(IDLE, 1'b1, 1'b1, rdatas[i]);
            check("ld_valid", msbus_o[71], 1);
            check("ld_res", msbus_o[31:0], ress[i]);
        end
        drive(IDLE, 1'b1, 1'b0, 32'h0);

        // Buffered response while writeback stalls for three cycles
        drive(mk(1'b1, 7'd12, 32'h8000_0200, 32'h0000_3000, 1'b1, 3'd4), 1'b1, 1'b0, 32'h0);
        exp_q.push_back(expv(7'd12, 32'h8000_0200, 32'hCAFE_F00D));
        drive(IDLE, 1'b0, 1'b1, 32'hCAFE_F00D);
        check("buf_valid0", msbus_o[71], 1);
        check("buf_allowin", ms_allowin, 0);
        for (int w = 0; w < 2; w++) begin
            drive(IDLE, 1'b0, 1'b0, 32'hDEAD_BEEF);
            check("buf_hold_valid", msbus_o[71], 1);
            check("buf_hold_res", msbus_o[31:0], 32'hCAFE_F00D);
        end
        drive(IDLE, 1'b1, 1'b1, 32'h1212_1212);
        check("buf_leave_res", msbus_o[31:0], 32'hCAFE_F00D);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("buf_gone", msbus_o[71], 0);
        drive(mk(1'b1, 7'd13, 32'h8000_0204, 32'h0000_3004, 1'b1, 3'd4), 1'b1, 1'b0, 32'h0);
        exp_q.push_back(expv(7'd13, 32'h8000_0204, 32'h0BAD_F00D));
        drive(IDLE, 1'b1, 1'b0, 32'h5A5A_5A5A);
        check("buf_cleared_valid", msbus_o[71], 0);
        check("buf_cleared_pending", fwdbus_o[37], 1);
        drive(IDLE, 1'b1, 1'b1, 32'h0BAD_F00D);
        check("buf_next_res", msbus_o[31:0], 32'h0BAD_F00D);

        // Back-to-back ALU ops with writeback toggling 1,0,1
        drive(mk(1'b1, 7'd4, 32'h8000_0300, 32'h0000_00AA, 1'b0, 3'd0), 1'b1, 1'b0, 32'h0);
        check("b2b_allowin_a", ms_allowin, 1);
        exp_q.push_back(expv(7'd4, 32'h8000_0300, 32'h0000_00AA));
        drive(mk(1'b1, 7'd5, 32'h8000_0304, 32'h0000_00BB, 1'b0, 3'd0), 1'b1, 1'b0, 32'h0);
        check("b2b_allowin_b", ms_allowin, 1);
        exp_q.push_back(expv(7'd5, 32'h8000_0304, 32'h0000_00BB));
        ld = mk(1'b1, 7'b0100000, 32'h8000_0308, 32'h0000_00CC, 1'b0, 3'd0);
        drive(ld, 1'b0, 1'b0, 32'h0);
        check("b2b_stall_allowin", ms_allowin, 0);
        drive(ld, 1'b1, 1'b0, 32'h0);
        check("b2b_allowin_c", ms_allowin, 1);
        exp_q.push_back(expv(7'b0100000, 32'h8000_0308, 32'h0000_00CC));
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("b2b_c_valid", msbus_o[71], 1);
        check("b2b_c_nofwd", fwdbus_o[38], 0);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("b2b_empty", exp_q.size(), 0);

        // Reset while a load is pending, followed by a stray response
        drive(mk(1'b1, 7'd7, 32'h8000_0400, 32'h0000_4000, 1'b1, 3'd4), 1'b1, 1'b0, 32'h0);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("rst_ld_pending", fwdbus_o[37], 1);
        reset = 1'b1;
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        drive(IDLE, 1'b1, 1'b1, 32'h5555_5555);
        check("rst_stray_valid", msbus_o[71], 0);
        check("rst_stray_allowin", ms_allowin, 1);
        check("rst_stray_fwd", fwdbus_o, 0);
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("rst_after_valid", msbus_o[71], 0);

        // Randomized traffic with a responder serving each load after a random delay
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wsa    = ($urandom_range(0, 3) != 0);
            served = 1'b0;
            rd     = $urandom();
            if (pend_rdata.size() > 0) begin
                if (pend_delay[0] == 0) begin
                    dok    = 1'b1;
                    rd     = pend_rdata[0];
                    served = 1'b1;
                end else begin
                    pend_delay[0] = pend_delay[0] - 1;
                    dok = 1'b0;
                end
            end else begin
                dok = ($urandom_range(0, 4) == 0);
            end
            es = rand_bus();
            drive(es, wsa, dok, rd);
            if (!served && pend_rdata.size() > 0) begin
                check("rnd_wait_valid", msbus_o[71], 0);
                check("rnd_wait_allowin", ms_allowin, 0);
                check("rnd_wait_pending", fwdbus_o[37], fwd_ok(pend_dest[0]));
            end
            if (served) begin
                void'(pend_rdata.pop_front());
                void'(pend_delay.pop_front());
                void'(pend_dest.pop_front());
            end
            if (es[75] && ms_allowin) begin
                rd2 = $urandom();
                exp_q.push_back(expv(es[74:68], es[67:36],
                                     es[3] ? load_model(es[2:0], es[35:4], rd2) : es[35:4]));
                if (es[3]) begin
                    pend_rdata.push_back(rd2);
                    pend_delay.push_back($urandom_range(0, 3));
                    pend_dest.push_back(es[74:68]);
                end
            end
        end

        // Drain: serve any outstanding load and let writeback accept everything
        for (int cyc = 0; cyc < 50 && exp_q.size() > 0; cyc++) begin
            if (pend_rdata.size() > 0) begin
                rd = pend_rdata[0];
                void'(pend_rdata.pop_front());
                void'(pend_delay.pop_front());
                void'(pend_dest.pop_front());
                drive(IDLE, 1'b1, 1'b1, rd);
            end else begin
                drive(IDLE, 1'b1, 1'b0, 32'h0);
            end
        end
        drive(IDLE, 1'b1, 1'b0, 32'h0);
        check("drain_empty", exp_q.size(), 0);
        check("drain_idle_valid", msbus_o[71], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vie_mem_stage.md
Name: vie_mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline, between the execute stage (upstream) and the writeback stage (downstream).
- Registers the execute-stage bus and waits for the data-SRAM response on loads; the response may take a variable number of cycles.
- Extracts and extends the load byte/halfword/word, and presents {valid, dest, pc, result} to writeback as the 72-bit msbus.
- Drives a forwarding bus to decode, including a pending flag for loads still waiting on data.

Parameters:
- none (all widths fixed by bus layouts below)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- esbus_i  in  76  [75] es_valid, [74:68] dest, [67:36] pc, [35:4] alu_res (result or load address), [3] is_load, [2:0] load_op
- ms_allowin  out  1  stage can accept esbus_i this cycle
- ws_allowin  in  1  writeback can accept msbus_o
- data_ok  in  1  data-SRAM read response valid (one pulse per load)
- data_rdata  in  32  data-SRAM read data, valid when data_ok=1
- msbus_o  out  72  [71] valid, [70:64] dest, [63:32] pc, [31:0] res
- fwdbus_o  out  39  [38] fwd_valid, [37] fwd_pending, [36:32] waddr, [31:0] wdata

Behaviour:
- State registers:
  - ms_valid_r: occupancy.
  - ms_r: 75-bit copy of esbus_i[74:0].
  - buf_valid, buf_data[31:0]: captured load response.
- Reset: all registers cleared to 0. Resulting outputs:
  - ms_allowin=1.
  - msbus_o=0.
  - fwdbus_o=0.
- Handshake:
  - ms_cango = !is_load | data_ok | buf_valid.
  - ms_allowin = !ms_valid_r | (ms_cango & ws_allowin).
- Occupancy update: if ms_allowin, ms_valid_r <= es_valid. If es_valid & ms_allowin, ms_r <= esbus_i[74:0]. No other cycle changes ms_r.
- Output valid: msbus_o[71] = ms_valid_r & ms_cango. Other msbus_o fields are driven from ms_r at all times.
- Load response buffer:
  - Capture: when ms_valid_r & is_load & data_ok & !buf_valid & !ws_allowin, set buf_valid<=1 and buf_data<=data_rdata.
  - Clear: buf_valid<=0 whenever the instruction leaves (msbus_o[71] & ws_allowin), and on reset.
  - Source select: raw load data = buf_valid ? buf_data : data_rdata.
- Spurious data_ok: ignored, with no state change, when !ms_valid_r, when !is_load, or when buf_valid=1.
- Load extension. a = alu_res[1:0]; raw = raw load data.
  - 000 lb: sign-extend raw byte a.
  - 001 lbu: zero-extend raw byte a.
  - 010 lh: sign-extend a[1] ? raw[31:16] : raw[15:0].
  - 011 lhu: zero-extend the same halfword.
  - 100 lw, and 101-111: raw unchanged.
  - Byte a means raw[8a+7:8a].
  - a[0] is ignored for halfwords and a is ignored for words. No alignment exceptions are raised in this stage.
- Result: res = is_load ? extended load data : alu_res. dest and pc pass through unchanged.
- Forwarding:
  - fwd_valid = ms_valid_r & (dest[6:5]==2'b00) & (dest[4:0]!=0).
  - fwd_pending = fwd_valid & !ms_cango. Decode must stall on a match while this is 1.
  - waddr = dest[4:0]; wdata = res.
- Latency:
  - Non-load: esbus_i accepted at edge N, so msbus_o valid during cycle N+1.
  - Load: msbus_o valid in the first cycle with data_ok or buf_valid.
  - With ws_allowin=1 and continuous es_valid, throughput is 1 instruction/cycle for non-loads.
- Simultaneous events:
  - Leave and accept in the same cycle: the new instruction replaces the old one, and buf_valid clears in that same cycle.
  - data_ok in the same cycle as ws_allowin: data passes straight through and nothing is buffered.
- Reset mid-load: the outstanding instruction is dropped and buf_valid cleared. A data_ok arriving after reset, while the stage is empty, is ignored.

Test Plan:
- Reset, then alu instr esbus dest=7'd3, pc=0xBFC00000, alu_res=0x12345678, ws_allowin=1 -> msbus_o={1,3,0xBFC00000,0x12345678} exactly one cycle after acceptance; fwd_valid=1, fwd_pending=0.
- lb, addr low=2'b01, data_ok 2 cycles late with rdata=0x0000_80FF -> ms_allowin=0 and fwd_pending=1 while waiting; then res=0xFFFFFF80. Repeat with lbu -> res=0x00000080.
- lh, a=2'b10, rdata=0x8001_7FFF -> res=0xFFFF8001. lhu -> res=0x00008001. lw -> res=0x80017FFF.
- lw, data_ok=1 with rdata=0xCAFEF00D while ws_allowin=0 for 3 cycles, data_rdata then changes to garbage -> msbus_o valid stays 1 with res=0xCAFEF00D; instruction leaves when ws_allowin=1; buf_valid=0 afterwards.
- Back-to-back non-loads with ws_allowin toggling 1,0,1 -> no instruction lost or duplicated; ms_allowin=0 only in the stalled cycle; dest=7'b0100000 yields msbus valid=1 but fwd_valid=0.
- Load pending, reset asserted one cycle, then stray data_ok -> msbus_o[71]=0, ms_allowin=1, no write reaches writeback.
